// File: rtl/pulse_pacer_if.sv
// Event/pulse bus between a requester and the pulse pacer.
// The master raises events; the slave (the pacer) reports pulses and status.
interface pulse_pacer_if #(
    parameter int CNT_W = 4
);
    logic             evt;
    logic             en;
    logic             clr_ovf;
    logic             pulse;
    logic [CNT_W-1:0] pending;
    logic             busy;
    logic             ovf;

    modport master (
        output evt, en, clr_ovf,
        input  pulse, pending, busy, ovf
    );

    modport slave (
        input  evt, en, clr_ovf,
        output pulse, pending, busy, ovf
    );
endinterface

// File: rtl/pulse_pacer.sv
// Turns bursts of event requests into single-cycle pulses spaced at least GAP
// cycles apart, counting events that are waiting and flagging any that are dropped.
module pulse_pacer #(
    parameter int GAP   = 4,
    parameter int CNT_W = 4
) (
    input  logic          clk,
    input  logic          rst,
    pulse_pacer_if.slave  bus
);
    localparam logic [7:0]       GAP_RELOAD = 8'(GAP - 1);
    localparam logic [CNT_W-1:0] PEND_MAX   = '1;

    logic             pulse_q, pulse_d;
    logic [CNT_W-1:0] pend_q,  pend_d;
    logic [7:0]       gcnt_q,  gcnt_d;
    logic             ovf_q,   ovf_d;
    logic             issue;
    logic             drop;

    // Returns {drop, next_count}; an increment at the ceiling is refused
    // unless an issue cancels it out in the same cycle.
    function automatic logic [CNT_W:0] pend_next(
        input logic [CNT_W-1:0] cur,
        input logic             inc,
        input logic             dec
    );
        logic [CNT_W-1:0] nxt;
        logic             dropped;
        nxt     = cur;
        dropped = 1'b0;
        if (inc && !dec) begin
            if (cur == PEND_MAX) begin
                dropped = 1'b1;
            end else begin
                nxt = cur + 1'b1;
            end
        end else if (dec && !inc) begin
            nxt = cur - 1'b1;
        end
        return {dropped, nxt};
    endfunction

    always_comb begin
        issue   = bus.en && (gcnt_q == 8'd0) && (pend_q != '0);
        pulse_d = issue;
        gcnt_d  = gcnt_q;
        if (issue) begin
            gcnt_d = GAP_RELOAD;
        end else if (gcnt_q != 8'd0) begin
            gcnt_d = gcnt_q - 8'd1;
        end
        {drop, pend_d} = pend_next(pend_q, bus.evt, issue);
        // A drop in the same cycle as a clear keeps the flag set.
        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (bus.clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pulse_q <= 1'b0;
            pend_q  <= '0;
            gcnt_q  <= 8'd0;
            ovf_q   <= 1'b0;
        end else begin
            pulse_q <= pulse_d;
            pend_q  <= pend_d;
            gcnt_q  <= gcnt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.pulse   = pulse_q;
    assign bus.pending = pend_q;
    assign bus.busy    = (pend_q != '0) || (gcnt_q != 8'd0);
    assign bus.ovf     = ovf_q;
endmodule
